uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Transmit-side buffer directly upstream of the UART top level. It accepts 9-bit words from host logic in single-cycle writes, stores them in a FIFO, and presents them one at a time to the UART's `i_tx_valid`/`i_tx_parallel` inputs. It handles the UART's two-stage valid synchronizer and its slow `o_ready` response with a hold-until-acknowledged handshake. A watchdog re-presents a word if the UART never acknowledges it.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, ≥ 2.
- `AW`, $clog2(DEPTH): pointer width (derived, not overridden).
- `ACK_TIMEOUT`, 64: cycles `o_tx_valid` may stay high without `i_uart_ready` falling before retry; ≥ 8.
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_wr_en`  in  1  write strobe; one word per cycle.
- `i_wr_data`  in  9  word to enqueue.
- `o_full`  out  1  FIFO holds DEPTH words.
- `o_empty`  out  1  FIFO holds 0 words.
- `o_count`  out  AW+1  current occupancy, 0..DEPTH.
- `o_overflow`  out  1  one-cycle pulse: write attempted while full; word dropped.
- `o_tx_valid`  out  1  to UART `i_tx_valid`.
- `o_tx_parallel`  out  9  to UART `i_tx_parallel`.
- `i_uart_ready`  in  1  from UART `o_ready`.
- `o_timeout`  out  1  one-cycle pulse: acknowledge watchdog expired.

## Operation
- FIFO: circular buffer with read/write pointers of AW bits that wrap modulo DEPTH, plus a registered count.
  - `o_full` = (count == DEPTH). `o_empty` = (count == 0).
  - A write when not full stores the word at the write pointer and advances it.
  - A write when full is ignored and pulses `o_overflow`.
  - A write and a pop in the same cycle leave count unchanged. This is allowed at count = DEPTH, because the pop frees a slot that same cycle.
- Handshake FSM, states IDLE, PRESENT, RELEASE:
  - **IDLE**
    - When `!o_empty && i_uart_ready`: latch the FIFO head into `o_tx_parallel`, set `o_tx_valid`, clear the watchdog, go to PRESENT.
  - **PRESENT**
    - When `!i_uart_ready` (acknowledge): clear `o_tx_valid`, pop the FIFO, go to RELEASE.
    - Otherwise, if the watchdog reaches ACK_TIMEOUT−1: clear `o_tx_valid`, pulse `o_timeout`, do not pop, go to RELEASE.
    - Otherwise increment the watchdog.
  - **RELEASE**
    - When `i_uart_ready`: go to IDLE.
    - `o_tx_valid` stays low, so the UART sees a clean falling edge before the next word.
- `o_tx_parallel` holds its value from entry into PRESENT until the next entry into PRESENT. The data is therefore stable for the entire frame, since the UART samples data unsynchronized.
- After a timeout the same head word is re-presented.

## Timing
- Reset (`i_rst_n` low at a clock edge) gives:
  - state IDLE;
  - pointers, count and watchdog = 0;
  - `o_tx_valid` = 0, `o_tx_parallel` = 0;
  - `o_empty` = 1, `o_full` = 0, `o_count` = 0;
  - `o_overflow` = 0, `o_timeout` = 0.
- Reset mid-frame discards all FIFO contents. `o_tx_valid` is low after that edge.
- All outputs are registered.
- Write at edge n: count and `o_empty` update at n+1.
- With the FSM in IDLE and `i_uart_ready` high, `o_tx_valid` rises at n+2. `o_tx_parallel` is valid from that same edge.
- `i_uart_ready` seen low at edge m: `o_tx_valid` falls and count decrements at m+1.
- `o_overflow` and `o_timeout` are high for exactly one cycle, on the edge following the causing event.
- Maximum throughput is one word per UART frame. FIFO write throughput is one word per cycle until full.

## Test plan
- **Reset values:** assert reset for 2 cycles → all outputs at the listed reset values. Write 0x1A5 with `i_uart_ready` = 1 → `o_count` = 1 one cycle later; `o_tx_valid` = 1 and `o_tx_parallel` = 0x1A5 two cycles after the write.
- **Acknowledge:** model the UART so `i_uart_ready` falls 3 cycles after `o_tx_valid` rises and returns 100 cycles later. Write 0x001, 0x0FF, 0x100 back-to-back → three presents in order. Each `o_tx_valid` pulse lasts 4 cycles. No re-present occurs before `i_uart_ready` returns high. Final `o_count` = 0.
- **Overflow and wrap:** with `i_uart_ready` = 0 and DEPTH = 16, write 17 words → `o_full` = 1 after 16 writes. The 17th write produces `o_overflow` for one cycle and `o_count` stays 16. Drain all words → the first 16 words appear in order.
- **Simultaneous write and pop:** at count = DEPTH, a write lands in the same cycle as an acknowledge pop → `o_count` stays 16 and the new word is delivered last.
- **Timeout:** hold `i_uart_ready` = 1 permanently after the first present → `o_timeout` pulses ACK_TIMEOUT cycles after `o_tx_valid` rises. `o_tx_valid` then drops for ≥ 1 cycle and the same word is re-presented. `o_count` is unchanged.
- **Reset mid-frame:** assert reset while in PRESENT with count = 5 → next cycle `o_tx_valid` = 0 and `o_count` = 0. No stale word is presented after reset is released.

Source files
------------

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: 9-bit transmit FIFO feeding a UART through a
// hold-until-acknowledged handshake. The UART acknowledges a word by
// dropping o_ready; a watchdog re-presents the head word if that never
// happens within ACK_TIMEOUT cycles.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  parameter int ACK_TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [8:0]    i_wr_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic          o_tx_valid,
  output logic [8:0]    o_tx_parallel,
  input  logic          i_uart_ready,
  output logic          o_timeout
);

  // Watchdog only needs to reach ACK_TIMEOUT-1.
  localparam int WW = $clog2(ACK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_overflow;
  logic          r_timeout;
  logic          r_tx_valid;
  logic [8:0]    r_tx_parallel;
  logic [WW-1:0] r_wdog;
  state_t        r_state;

  logic          w_pop;
  logic          w_wr_ok;
  logic [AW:0]   w_count_next;

  // Pop on acknowledge; a write is accepted when a slot is free or is freed by this cycle's pop.
  always_comb begin
    w_pop        = 1'b0;
    w_wr_ok      = 1'b0;
    w_count_next = r_count;
    if ((r_state == PRESENT) && !i_uart_ready) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
    w_wr_ok = i_wr_en && (!r_full || w_pop);
    if (w_wr_ok && !w_pop) begin
      w_count_next = r_count + (AW+1)'(1);
    end else if (!w_wr_ok && w_pop) begin
      w_count_next = r_count - (AW+1)'(1);
    end else begin
      w_count_next = r_count;
    end
  end

  // Storage array; contents need no reset because pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count    <= w_count_next;
      r_empty    <= (w_count_next == (AW+1)'(0));
      r_full     <= (w_count_next == (AW+1)'(DEPTH));
      r_overflow <= i_wr_en && !w_wr_ok;
    end
  end

  // Handshake FSM: present head word, wait for ready to fall (or watchdog), then wait for ready to return.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= IDLE;
      r_tx_valid    <= 1'b0;
      r_tx_parallel <= 9'd0;
      r_wdog        <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_empty && i_uart_ready) begin
            r_tx_parallel <= r_mem[r_rd_ptr];
            r_tx_valid    <= 1'b1;
            r_wdog        <= '0;
            r_state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (!i_uart_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= RELEASE;
          end else if (r_wdog == WW'(ACK_TIMEOUT - 1)) begin
            // Head word is not popped, so the next present repeats it.
            r_tx_valid <= 1'b0;
            r_timeout  <= 1'b1;
            r_state    <= RELEASE;
          end else begin
            r_wdog <= r_wdog + WW'(1);
          end
        end
        RELEASE: begin
          if (i_uart_ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_full        = r_full;
  assign o_empty       = r_empty;
  assign o_count       = r_count;
  assign o_overflow    = r_overflow;
  assign o_tx_valid    = r_tx_valid;
  assign o_tx_parallel = r_tx_parallel;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Self-checking bench for uart_tx_buffer: a queue-based reference model
// predicts occupancy, overflow, timeout and presented words every cycle,
// driven by directed scenarios and a randomized UART/host phase.
module tb_uart_tx_buffer;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int ACK   = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [8:0]  wr_data;
  logic        uart_ready;
  logic        o_full;
  logic        o_empty;
  logic [AW:0] o_count;
  logic        o_overflow;
  logic        o_tx_valid;
  logic [8:0]  o_tx_parallel;
  logic        o_timeout;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_tx_valid(o_tx_valid),
    .o_tx_parallel(o_tx_parallel), .i_uart_ready(uart_ready),
    .o_timeout(o_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [8:0] q[$];
  int hi_cnt = 0;
  logic [8:0] presented[$];
  int rises = 0;
  int v_len = 0;
  bit chk_len = 1'b0;

  // UART behaviour: mode 0 = ready driven by scenario, mode 1 = modelled UART
  int mode = 0;
  int u_fall = 3;
  int u_back = 100;
  int u_cnt = 0;
  int u_low = 0;
  bit rand_uart = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic pick_uart();
    u_fall = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 5));
    u_back = $urandom_range(1, 12);
  endtask

  // One clock: predict from pre-edge values, advance, check, then update UART model.
  task automatic step();
    bit pop, acc, ovf_e, tmo_e, rst_e, prev_v;
    logic [8:0] wd;
    rst_e  = !rst_n;
    pop    = o_tx_valid && !uart_ready;
    tmo_e  = 1'b0;
    if (o_tx_valid && uart_ready) begin
      hi_cnt++;
      tmo_e = (hi_cnt == ACK);
    end else begin
      hi_cnt = 0;
    end
    acc    = wr_en && ((q.size() < DEPTH) || pop);
    ovf_e  = wr_en && !acc;
    prev_v = o_tx_valid;
    wd     = wr_data;
    @(posedge clk);
    #1;
    if (rst_e) begin
      q.delete();
      hi_cnt = 0;
      ovf_e  = 1'b0;
      tmo_e  = 1'b0;
      check_eq("rst_data", o_tx_parallel, 0);
    end else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(wd);
    end
    check_eq("count", o_count, q.size());
    check_eq("empty", o_empty, int'(q.size() == 0));
    check_eq("full", o_full, int'(q.size() == DEPTH));
    check_eq("overflow", o_overflow, ovf_e);
    check_eq("timeout", o_timeout, tmo_e);
    if (rst_e || pop || tmo_e) check_eq("valid_low", o_tx_valid, 0);
    if (!prev_v && o_tx_valid) begin
      rises++;
      presented.push_back(o_tx_parallel);
      check_eq("present_nonempty", int'(q.size() > 0), 1);
      if (q.size() > 0) check_eq("present_head", o_tx_parallel, q[0]);
    end
    if (o_tx_valid) begin
      v_len++;
    end else begin
      if (prev_v && chk_len) check_eq("pulse_len", v_len, 4);
      v_len = 0;
    end
    if (mode == 1) begin
      if (u_low > 0) begin
        u_low--;
        if (u_low == 0) begin
          uart_ready = 1'b1;
          if (rand_uart) pick_uart();
        end
      end else if (o_tx_valid) begin
        u_cnt++;
        if (u_cnt == u_fall + 1) begin
          uart_ready = 1'b0;
          u_low = u_back;
          u_cnt = 0;
        end
      end else begin
        if (u_cnt > 0 && rand_uart) pick_uart();
        u_cnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 9'd0;
    step();
    step();
    rst_n = 1'b1;
    mode = 0;
    u_cnt = 0;
    u_low = 0;
    rand_uart = 1'b0;
    chk_len = 1'b0;
    v_len = 0;
    rises = 0;
    presented.delete();
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int r0;
    int k;
    r0 = rises;
    k = 0;
    while (rises == r0 && k < budget) begin
      step();
      k++;
    end
    check_eq(tag, int'(rises > r0), 1);
  endtask

  task automatic write_word(input logic [8:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [8:0] data [17];
    logic [8:0] extra;
    int k;
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = 9'd0;
    uart_ready = 1'b0;

    // Reset values and first-present latency
    do_reset();
    check_eq("reset_valid", o_tx_valid, 0);
    check_eq("reset_count", o_count, 0);
    check_eq("reset_empty", o_empty, 1);
    uart_ready = 1'b1;
    write_word(9'h1A5);
    check_eq("lat_count", o_count, 1);
    check_eq("lat_valid0", o_tx_valid, 0);
    step();
    check_eq("lat_valid1", o_tx_valid, 1);
    check_eq("lat_data", o_tx_parallel, 9'h1A5);

    // Acknowledge with a slow UART
    do_reset();
    uart_ready = 1'b1;
    mode = 1; u_fall = 3; u_back = 100; chk_len = 1'b1;
    write_word(9'h001);
    write_word(9'h0FF);
    write_word(9'h100);
    k = 0;
    while ((q.size() > 0 || !uart_ready) && k < 1000) begin step(); k++; end
    repeat (5) step();
    check_eq("ack_presents", presented.size(), 3);
    if (presented.size() == 3) begin
      check_eq("ack_w0", presented[0], 9'h001);
      check_eq("ack_w1", presented[1], 9'h0FF);
      check_eq("ack_w2", presented[2], 9'h100);
    end
    check_eq("ack_final_count", o_count, 0);
    chk_len = 1'b0;

    // Overflow, then write coinciding with a pop at full, then drain
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      data[i] = 9'($urandom_range(0, 511));
      write_word(data[i]);
      if (i == 15) check_eq("ovf_full", o_full, 1);
    end
    check_eq("ovf_pulse", o_overflow, 1);
    check_eq("ovf_count", o_count, 16);
    step();
    check_eq("ovf_once", o_overflow, 0);
    mode = 1; u_fall = 3; u_back = 5;
    uart_ready = 1'b1;
    k = 0;
    while (!(o_tx_valid && !uart_ready) && k < 500) begin step(); k++; end
    check_eq("sim_reached", int'(o_tx_valid && !uart_ready), 1);
    extra = 9'($urandom_range(0, 511));
    write_word(extra);
    check_eq("sim_count", o_count, 16);
    k = 0;
    while (presented.size() < 17 && k < 3000) begin step(); k++; end
    check_eq("drain_presents", presented.size(), 17);
    if (presented.size() == 17) begin
      for (int i = 0; i < 16; i++) check_eq($sformatf("drain_w%0d", i), presented[i], data[i]);
      check_eq("drain_last", presented[16], extra);
    end

    // Watchdog timeout and re-present
    do_reset();
    uart_ready = 1'b1;
    write_word(9'h0AB);
    wait_rise(10, "tmo_first_present");
    k = 0;
    while (!o_timeout && k < 200) begin step(); k++; end
    check_eq("tmo_delay", k, ACK);
    k = 0;
    while (!o_tx_valid && k < 20) begin step(); k++; end
    check_eq("tmo_gap", int'(k >= 2), 1);
    check_eq("tmo_repres", o_tx_parallel, 9'h0AB);
    check_eq("tmo_count", o_count, 1);

    // Reset while presenting with five words queued
    do_reset();
    uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_word(9'($urandom_range(0, 511)));
    uart_ready = 1'b1;
    wait_rise(10, "mid_present");
    check_eq("mid_count5", o_count, 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("mid_valid", o_tx_valid, 0);
    check_eq("mid_count", o_count, 0);
    k = rises;
    repeat (20) step();
    check_eq("mid_no_stale", rises, k);

    // Randomized host writes against a randomized UART
    do_reset();
    uart_ready = 1'b1;
    mode = 1; rand_uart = 1'b1;
    pick_uart();
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_data = 9'($urandom_range(0, 511));
      step();
    end
    wr_en = 1'b0;
    k = 0;
    while ((q.size() > 0 || o_tx_valid) && k < 8000) begin step(); k++; end
    check_eq("rand_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
